// File: rtl/ctrl_bus_pkg.sv
// ctrl_bus_pkg
// Shared types and constants for the control bus bridge.
//   - state_t      : bridge FSM states
//   - tag_t        : {block idx, sel, addr} identifying one 64-bit bank register
//   - *_MSB/*_LSB  : bit positions of the fields inside a host word address
//   - blockOneHot  : block index to one-hot chip-select decode
package ctrl_bus_pkg;

  localparam int CS_COUNT_DEF = 9;

  localparam int IDX_MSB  = 13;
  localparam int IDX_LSB  = 10;
  localparam int SEL_MSB  = 9;
  localparam int SEL_LSB  = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 1;
  localparam int HALF_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    BUS_WR,
    BUS_RD,
    RD_CAPT,
    RESP
  } state_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [1:0] sel;
    logic [6:0] addr;
  } tag_t;

  // Full 16-entry decode of the 4-bit block index. Bits at or above the
  // number of real banks flag an out-of-range index.
  function automatic logic [15:0] blockOneHot(input logic [3:0] idx);
    blockOneHot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/control_bus_bridge.sv
// control_bus_bridge
// Host-side front end of the control register bank. Turns single-outstanding
// 32-bit host word requests into 64-bit bank accesses: writes are assembled
// from a low-half shadow plus the high-half request, reads go through a read
// shadow so the second half of a 64-bit register is served without a bus trip.
//
// Ports:
//   control_clk, control_rst_n : clock, synchronous active-low reset
//   req_valid/req_ready        : host request handshake
//   req_write, req_addr        : op and word address {idx, sel, addr, half}
//   req_wdata                  : 32-bit write data
//   resp_valid/resp_ready      : host response handshake
//   resp_rdata, resp_err       : read data (0 on writes/errors), bad-index flag
//   cs, sel, addr, we, r_in    : registered bank-side request
//   r_out                      : bank read data, valid one cycle after cs
module control_bus_bridge
  import ctrl_bus_pkg::*;
#(
  parameter int CS_COUNT = CS_COUNT_DEF,
  parameter int HOST_AW  = 14
) (
  input  logic                control_clk,
  input  logic                control_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [HOST_AW-1:0]  req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [CS_COUNT-1:0] cs,
  output logic [1:0]          sel,
  output logic [6:0]          addr,
  output logic [63:0]         r_in,
  output logic                we,
  input  logic [63:0]         r_out
);

  state_t r_state;
  state_t w_nextState;

  logic [CS_COUNT-1:0] r_cs;
  logic [1:0]          r_sel;
  logic [6:0]          r_addr;
  logic [63:0]         r_rIn;
  logic                r_we;
  logic [31:0]         r_respRdata;
  logic                r_respErr;
  logic [31:0]         r_wrShadowLo;
  logic [63:0]         r_rdShadow;
  logic                r_rdShadowValid;
  tag_t                r_shadowTag;
  tag_t                r_curTag;
  logic                r_curHalf;

  logic [3:0]  w_idx;
  logic [1:0]  w_sel;
  logic [6:0]  w_addr;
  logic        w_half;
  tag_t        w_reqTag;
  logic [15:0] w_oneHot;
  logic        w_badIdx;
  logic        w_shadowHit;

  // Split the host word address into its bank fields and pre-compute the
  // decode results that the IDLE state acts on.
  assign w_idx       = req_addr[IDX_MSB:IDX_LSB];
  assign w_sel       = req_addr[SEL_MSB:SEL_LSB];
  assign w_addr      = req_addr[ADDR_MSB:ADDR_LSB];
  assign w_half      = req_addr[HALF_BIT];
  assign w_reqTag    = {w_idx, w_sel, w_addr};
  assign w_oneHot    = blockOneHot(w_idx);
  assign w_badIdx    = |w_oneHot[15:CS_COUNT];
  assign w_shadowHit = r_rdShadowValid && (r_shadowTag == w_reqTag);

  // Deriving the handshake flags from distinct states keeps req_ready and
  // resp_valid mutually exclusive by construction.
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;
  assign cs         = r_cs;
  assign sel        = r_sel;
  assign addr       = r_addr;
  assign r_in       = r_rIn;
  assign we         = r_we;

  // State register.
  always_ff @(posedge control_clk) begin
    if (!control_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode. Only a write-hi or a read that misses the shadow
  // touches the bank; everything else answers straight from IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_badIdx) begin
            w_nextState = RESP;
          end else if (req_write) begin
            w_nextState = w_half ? BUS_WR : RESP;
          end else if (w_half && w_shadowHit) begin
            w_nextState = RESP;
          end else begin
            w_nextState = BUS_RD;
          end
        end
      end
      BUS_WR:  w_nextState = RESP;
      BUS_RD:  w_nextState = RD_CAPT;
      RD_CAPT: w_nextState = RESP;
      RESP:    if (resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: bank-side request registers, write/read shadows and the
  // response registers. Reset drops cs/we at the same edge, which abandons
  // any access in flight without ever producing a response.
  always_ff @(posedge control_clk) begin
    if (!control_rst_n) begin
      r_cs            <= '0;
      r_sel           <= '0;
      r_addr          <= '0;
      r_rIn           <= '0;
      r_we            <= 1'b0;
      r_respRdata     <= '0;
      r_respErr       <= 1'b0;
      r_wrShadowLo    <= '0;
      r_rdShadow      <= '0;
      r_rdShadowValid <= 1'b0;
      r_shadowTag     <= '0;
      r_curTag        <= '0;
      r_curHalf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_curTag  <= w_reqTag;
            r_curHalf <= w_half;
            if (w_badIdx) begin
              r_respErr   <= 1'b1;
              r_respRdata <= '0;
            end else if (req_write) begin
              if (!w_half) begin
                r_wrShadowLo <= req_wdata;
              end else begin
                r_rIn  <= {req_wdata, r_wrShadowLo};
                r_cs   <= w_oneHot[CS_COUNT-1:0];
                r_we   <= 1'b1;
                r_sel  <= w_sel;
                r_addr <= w_addr;
              end
            end else if (w_half && w_shadowHit) begin
              r_respRdata <= r_rdShadow[63:32];
            end else begin
              r_cs   <= w_oneHot[CS_COUNT-1:0];
              r_we   <= 1'b0;
              r_sel  <= w_sel;
              r_addr <= w_addr;
            end
          end
        end
        BUS_WR: begin
          r_cs <= '0;
          r_we <= 1'b0;
          // The bank now holds newer data than the shadow for this register.
          if (r_curTag == r_shadowTag) begin
            r_rdShadowValid <= 1'b0;
          end
        end
        BUS_RD: begin
          r_cs <= '0;
        end
        RD_CAPT: begin
          r_rdShadow      <= r_out;
          r_shadowTag     <= r_curTag;
          r_rdShadowValid <= 1'b1;
          r_respRdata     <= r_curHalf ? r_out[63:32] : r_out[31:0];
        end
        RESP: begin
          if (resp_ready) begin
            r_respRdata <= '0;
            r_respErr   <= 1'b0;
          end
        end
        default: begin
          r_cs <= '0;
          r_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_bus_bridge.sv
// tb_control_bus_bridge
// Directed testbench for control_bus_bridge with a behavioural register bank
// (registered read, one cycle after cs) and a cs activity monitor.
module tb_control_bus_bridge;

  logic        control_clk;
  logic        control_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [8:0]  cs;
  logic [1:0]  sel;
  logic [6:0]  addr;
  logic [63:0] r_in;
  logic        we;
  logic [63:0] r_out;

  int checks   = 0;
  int failures = 0;

  int          csCount = 0;
  logic [8:0]  lastCs;
  logic        lastWe;
  logic [63:0] lastRIn;

  int          gotLatency;
  logic [31:0] gotRdata;
  logic        gotErr;
  int          gotCs;

  logic [63:0] bankMem [0:8191];

  control_bus_bridge dut (
    .control_clk   (control_clk),
    .control_rst_n (control_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .cs            (cs),
    .sel           (sel),
    .addr          (addr),
    .r_in          (r_in),
    .we            (we),
    .r_out         (r_out)
  );

  // Free-running clock.
  initial begin
    control_clk = 1'b0;
    forever #5 control_clk = ~control_clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] csToIdx(input logic [8:0] c);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (c[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Bank model: preset contents, write on cs&we, registered read otherwise.
  initial begin
    for (int i = 0; i < 8192; i++) bankMem[i] = 64'd0;
    bankMem[13'h018] = 64'h5A5A0000_20240115;
  end

  always @(posedge control_clk) begin
    if (cs != 9'd0) begin
      if (we) bankMem[{csToIdx(cs), sel, addr}] <= r_in;
      else    r_out <= bankMem[{csToIdx(cs), sel, addr}];
    end
  end

  // Record every cycle in which the bridge drives the bank.
  always @(negedge control_clk) begin
    if (cs != 9'd0) begin
      csCount <= csCount + 1;
      lastCs  <= cs;
      lastWe  <= we;
      lastRIn <= r_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  // Issue one request and wait (bounded) for resp_valid; leaves the response
  // pending so the caller can choose when to accept it.
  task automatic applyStimulus(input logic wr, input logic [13:0] a,
                               input logic [31:0] d);
    int cyc;
    int csStart;
    csStart   = csCount;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge control_clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge control_clk); #1;
      cyc++;
    end
    if (!resp_valid) checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
    gotLatency = cyc;
    gotRdata   = resp_rdata;
    gotErr     = resp_err;
    gotCs      = csCount - csStart;
  endtask

  task automatic acceptResponse();
    resp_ready = 1'b1;
    @(posedge control_clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic doTransaction(input logic wr, input logic [13:0] a,
                               input logic [31:0] d);
    applyStimulus(wr, a, d);
    acceptResponse();
  endtask

  initial begin
    control_rst_n = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    resp_ready    = 1'b0;
    r_out         = '0;
    repeat (3) @(posedge control_clk);
    #1;
    control_rst_n = 1'b1;

    // Reset state.
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    checkOutput("rst_bank", 64'({cs, we, sel, addr}), 64'd0);
    checkOutput("rst_r_in", r_in, 64'd0);

    // Idle: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(posedge control_clk); #1;
      checkOutput("idle", 64'({cs, we, resp_valid, req_ready}), 64'h1);
    end

    // Write idx0 reg 0x00: lo then hi.
    doTransaction(1'b1, 14'h0000, 32'hDEADBEEF);
    checkOutput("wrlo_latency", 64'(gotLatency), 64'd1);
    checkOutput("wrlo_cs_cycles", 64'(gotCs), 64'd0);
    checkOutput("wrlo_rdata_err", 64'({gotErr, gotRdata}), 64'd0);
    doTransaction(1'b1, 14'h0001, 32'h01234567);
    checkOutput("wrhi_latency", 64'(gotLatency), 64'd2);
    checkOutput("wrhi_cs_cycles", 64'(gotCs), 64'd1);
    checkOutput("wrhi_cs", 64'(lastCs), 64'h001);
    checkOutput("wrhi_we", 64'(lastWe), 64'd1);
    checkOutput("wrhi_r_in", lastRIn, 64'h01234567_DEADBEEF);
    checkOutput("wrhi_resp_cleared", 64'({resp_err, resp_rdata}), 64'd0);

    // Read reg 0x18 lo (bus) then hi (shadow hit).
    doTransaction(1'b0, 14'h0030, 32'd0);
    checkOutput("rdlo_latency", 64'(gotLatency), 64'd3);
    checkOutput("rdlo_rdata", 64'(gotRdata), 64'h20240115);
    checkOutput("rdlo_cs_cycles", 64'(gotCs), 64'd1);
    checkOutput("rdlo_we", 64'(lastWe), 64'd0);
    doTransaction(1'b0, 14'h0031, 32'd0);
    checkOutput("rdhi_latency", 64'(gotLatency), 64'd1);
    checkOutput("rdhi_rdata", 64'(gotRdata), 64'h5A5A0000);
    checkOutput("rdhi_cs_cycles", 64'(gotCs), 64'd0);

    // Shadow invalidation on reg0.
    doTransaction(1'b0, 14'h0000, 32'd0);
    checkOutput("inv_rdlo_rdata", 64'(gotRdata), 64'hDEADBEEF);
    doTransaction(1'b1, 14'h0000, 32'h11112222);
    doTransaction(1'b1, 14'h0001, 32'h33334444);
    checkOutput("inv_wr_r_in", lastRIn, 64'h33334444_11112222);
    doTransaction(1'b0, 14'h0001, 32'd0);
    checkOutput("inv_rdhi_cs_cycles", 64'(gotCs), 64'd1);
    checkOutput("inv_rdhi_latency", 64'(gotLatency), 64'd3);
    checkOutput("inv_rdhi_rdata", 64'(gotRdata), 64'h33334444);

    // Bad block indices (15 and the first out-of-range value 9).
    doTransaction(1'b0, 14'h3C00, 32'd0);
    checkOutput("bad15_rd", 64'({gotErr, gotRdata}), 64'h1_00000000);
    checkOutput("bad15_rd_cs", 64'(gotCs), 64'd0);
    checkOutput("bad15_rd_latency", 64'(gotLatency), 64'd1);
    doTransaction(1'b1, 14'h3C01, 32'hCAFEF00D);
    checkOutput("bad15_wr", 64'({gotErr, gotRdata}), 64'h1_00000000);
    checkOutput("bad15_wr_cs", 64'(gotCs), 64'd0);
    doTransaction(1'b0, 14'h2400, 32'd0);
    checkOutput("bad9_rd", 64'({gotErr, gotRdata}), 64'h1_00000000);
    checkOutput("bad9_rd_cs", 64'(gotCs), 64'd0);
    checkOutput("err_cleared", 64'({resp_err, resp_rdata}), 64'd0);

    // Next valid request succeeds; reg 0x18 hi is no longer shadowed.
    doTransaction(1'b0, 14'h0031, 32'd0);
    checkOutput("post_err_rd", 64'({gotErr, gotRdata}), 64'h0_5A5A0000);
    checkOutput("post_err_latency", 64'(gotLatency), 64'd3);

    // Highest valid block (idx 8) write-hi reuses the persisting low shadow.
    doTransaction(1'b1, 14'h2001, 32'hAAAA5555);
    checkOutput("idx8_cs", 64'(lastCs), 64'h100);
    checkOutput("idx8_r_in", lastRIn, 64'hAAAA5555_11112222);
    checkOutput("idx8_err", 64'(gotErr), 64'd0);

    // Back-pressure: response held stable while resp_ready is low.
    applyStimulus(1'b0, 14'h0030, 32'd0);
    checkOutput("bp_first_rdata", 64'(gotRdata), 64'h20240115);
    for (int i = 0; i < 10; i++) begin
      @(posedge control_clk); #1;
      checkOutput("bp_hold", 64'({resp_valid, req_ready, resp_rdata}),
                  64'h2_20240115);
    end
    acceptResponse();
    checkOutput("bp_released", 64'({resp_valid, req_ready}), 64'h1);

    // Reset during BUS_RD abandons the read.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 14'h0030;
    @(posedge control_clk); #1;
    req_valid = 1'b0;
    checkOutput("rst_mid_cs_active", 64'(cs), 64'h001);
    control_rst_n = 1'b0;
    @(posedge control_clk); #1;
    checkOutput("rst_mid_cs_dropped", 64'({cs, resp_valid}), 64'd0);
    control_rst_n = 1'b1;
    @(posedge control_clk); #1;
    checkOutput("rst_mid_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge control_clk); #1;
      checkOutput("rst_mid_no_resp", 64'({resp_valid, cs}), 64'd0);
    end

    // Read shadow was cleared by reset, so hi goes back to the bus.
    doTransaction(1'b0, 14'h0031, 32'd0);
    checkOutput("post_rst_latency", 64'(gotLatency), 64'd3);
    checkOutput("post_rst_rdata", 64'(gotRdata), 64'h5A5A0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
